bfp_renorm: RTL and testbench
=============================

Name: bfp_renorm

Overview:
- Inverse of the block-exponent path: takes one block of NUM block-floating-point mantissas that share a single exponent.
- Emits NUM individually normalised (sign, exponent, mantissa) elements serially, one per handshake.
- Sits after the FFT butterfly/block-scaling datapath. Converts block-FP results back to per-element FP for output and storage.
- A block is loaded in parallel, then streamed out through a registered valid/ready interface.

Parameters:
- expWidth, 4, width of shared and per-element exponent (unsigned).
- manWidth, 8, mantissa width; MSB = sign, low manWidth-1 bits = magnitude.
- NUM, 32, elements per block; idxWidth = clog2(NUM).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  block present on in_exp/in_man.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_exp  input  expWidth  shared block exponent.
- in_man  input  NUM*manWidth  mantissas; element i = in_man[manWidth*(i+1)-1 : manWidth*i].
- out_valid  output  1  output element valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_sign  output  1  element sign.
- out_exp  output  expWidth  element exponent.
- out_man  output  manWidth-1  normalised magnitude.
- out_idx  output  idxWidth  element index 0..NUM-1.
- out_last  output  1  high with element NUM-1.

Behaviour:
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_exp=0, out_man=0, out_idx=0, out_last=0, internal counter=0. rst asserted mid-block discards the block; nothing further is emitted.
- FSM, two states, IDLE and RUN:
  - IDLE: in_ready=1. On in_valid, register in_exp and all of in_man, clear the counter, go to RUN. in_ready=0 in RUN.
  - RUN: the output register loads element[counter] when !out_valid || out_ready (load enable). The counter increments on each load.
  - After element NUM-1 is loaded, stop loading. When out_valid && out_ready && out_last, clear out_valid and return to IDLE. in_ready=1 on the next cycle.
- Latency: element 0 is valid on the cycle after the input handshake. With out_ready held high, elements stream one per cycle, so NUM cycles from first to last. The block-to-block gap is 1 idle cycle after the last handshake.
- Backpressure: while out_valid && !out_ready, all out_* are held stable.
- Arithmetic per element:
  - m = magnitude (manWidth-1 bits); lz = leading-zero count of m.
  - If m==0: out_exp=0, out_man=0, out_sign=0. Sign is forced positive for zero.
  - Else if lz <= E (shared exponent): out_man = m << lz, so the MSB is 1; out_exp = E - lz.
  - Else (underflow): out_man = m << E; out_exp = 0. This is a denormal result with no wrap.
  - Otherwise out_sign = element sign bit.
- out_idx = element index; out_last = (out_idx == NUM-1) while valid.
- in_valid while not in_ready is ignored; the input data need not be held.

Test Plan (expWidth=4, manWidth=8, NUM=32):
- Normalise: E=9, element0 = sign 1, mag 0x10 -> out_sign=1, out_man=0x40, out_exp=7, out_idx=0, valid 1 cycle after accept.
- Underflow/zero: E=3, element0 mag 0x01 -> out_man=0x08, out_exp=0. Element1 = 0x80 (negative zero) -> sign 0, man 0, exp 0.
- Streaming: out_ready=1, all mags 0x7F, E=15 -> 32 consecutive beats with exp=15, man=0x7F, idx 0..31, out_last only on idx 31. in_ready returns 1 the cycle after.
- Backpressure: out_ready toggled randomly/held low 5 cycles at idx 7 -> outputs are stable while stalled; sequence is complete and in order with no duplicates or drops.
- Input gating: in_valid pulsed during RUN -> ignored; in_ready=0; the current block is unaffected.
- Reset mid-block: rst at idx 12 -> next cycle out_valid=0, in_ready=1, all outputs 0. A new block then starts at idx 0.

Source files
------------

// File: rtl/bfp_renorm.sv
// bfp_renorm: unpacks a block-FP block into serially streamed, individually normalised FP elements
module bfp_renorm #(
  parameter int expWidth = 4,
  parameter int manWidth = 8,
  parameter int NUM = 32,
  localparam int idxWidth = $clog2(NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [expWidth-1:0]      in_exp,
  input  logic [NUM*manWidth-1:0]  in_man,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [expWidth-1:0]      out_exp,
  output logic [manWidth-2:0]      out_man,
  output logic [idxWidth-1:0]      out_idx,
  output logic                     out_last
);
  localparam int MW = manWidth - 1;
  localparam int LW = (expWidth > $clog2(manWidth)) ? expWidth : $clog2(manWidth);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [expWidth-1:0] e_q;
  logic [NUM*manWidth-1:0] man_q;
  logic [idxWidth:0] cnt;
  logic [manWidth-1:0] el;
  logic [MW-1:0] m;
  logic [LW-1:0] lz, e_x;
  logic load, fire_last;
  logic n_sign;
  logic [expWidth-1:0] n_exp;
  logic [MW-1:0] n_man;
  assign el = man_q[cnt[idxWidth-1:0]*manWidth +: manWidth];
  assign m = el[MW-1:0];
  assign e_x = LW'(e_q);
  assign in_ready = (state == IDLE);
  assign load = (state == RUN) && (cnt != (idxWidth+1)'(NUM)) && (!out_valid || out_ready);
  assign fire_last = out_valid && out_ready && out_last;
  // lz ends as the distance of the highest set bit from the magnitude MSB
  always_comb begin
    lz = LW'(MW);
    for (int i = 0; i < MW; i++)
      if (m[i]) lz = LW'(MW - 1 - i);
  end
  // when lz exceeds the exponent we can only shift by E, leaving a denormal
  always_comb begin
    n_sign = (m != '0) & el[manWidth-1];
    n_exp = (m == '0 || lz > e_x) ? '0 : e_q - lz[expWidth-1:0];
    n_man = (lz <= e_x) ? m << lz : m << e_q;
  end
  always_comb begin
    state_n = (state == IDLE && in_valid) ? RUN : (state == RUN && fire_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      e_q <= '0;
      man_q <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_sign <= 1'b0;
      out_exp <= '0;
      out_man <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        e_q <= in_exp;
        man_q <= in_man;
        cnt <= '0;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_sign <= n_sign;
        out_exp <= n_exp;
        out_man <= n_man;
        out_idx <= cnt[idxWidth-1:0];
        out_last <= (cnt[idxWidth-1:0] == idxWidth'(NUM - 1));
        cnt <= cnt + 1'b1;
      end else if (fire_last) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bfp_renorm.sv
// tb_bfp_renorm: directed checks of bfp_renorm against an iterative-shift reference
module tb_bfp_renorm;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, out_sign, out_last;
  logic [3:0] in_exp = '0, out_exp;
  logic [255:0] in_man = '0;
  logic [6:0] out_man;
  logic [4:0] out_idx;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] me;
  logic [255:0] mblk, d;
  int beats, cycs;
  always #5 clk = ~clk;
  bfp_renorm #(.expWidth(4), .manWidth(8), .NUM(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
    .in_man(in_man), .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_man(out_man), .out_idx(out_idx), .out_last(out_last)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] ref_norm(input logic [3:0] e, input logic [7:0] v);
    logic [6:0] m;
    logic [3:0] x;
    m = v[6:0];
    x = e;
    if (m == 0) return 12'h0;
    while (!m[6] && x != 0) begin
      m = m << 1;
      x = x - 1;
    end
    return {v[7], x, m};
  endfunction
  function automatic logic [255:0] rnd_blk;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic load(input logic [3:0] e, input logic [255:0] dat);
    me = e;
    mblk = dat;
    in_exp = e;
    in_man = dat;
    in_valid = 1;
    check("accept_ready", in_ready, 1);
    step;
    in_valid = 0;
    in_man = rnd_blk();
    in_exp = 4'($urandom);
  endtask
  task automatic collect(input int start, input bit rnd, input bit gate, output int nb, output int nc);
    int idx, hold;
    bit stall, done, did_hold, did_gate;
    logic [18:0] held;
    idx = start; hold = 0; stall = 0; done = 0; did_hold = 0; did_gate = 0; held = '0;
    nb = 0; nc = 0;
    while (!done && nc < 300) begin
      if (rnd && !did_hold && out_valid && out_idx == 5'd7) begin
        did_hold = 1;
        hold = 5;
      end
      if (hold > 0) begin
        out_ready = 0;
        hold--;
      end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) check("stall_stable", {out_valid, out_sign, out_exp, out_man, out_idx, out_last}, held);
      if (gate && !did_gate && out_valid && out_idx == 5'd3) begin
        did_gate = 1;
        in_valid = 1;
        in_exp = ~me;
        in_man = rnd_blk();
        check("gate_in_ready", in_ready, 0);
      end else in_valid = 0;
      if (out_valid && out_ready) begin
        check("beat_idx", out_idx, idx);
        check("beat_elem", {out_sign, out_exp, out_man}, ref_norm(me, mblk[idx*8 +: 8]));
        check("beat_last", out_last, idx == 31);
        nb++;
        idx++;
        if (out_last) done = 1;
      end
      stall = out_valid && !out_ready;
      held = {out_valid, out_sign, out_exp, out_man, out_idx, out_last};
      nc++;
      step;
    end
    in_valid = 0;
    if (!done) check("collect_timeout", 0, 1);
  endtask
  initial begin
    repeat (2) step;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", {out_sign, out_exp, out_man, out_idx, out_last}, 0);
    rst = 0;
    step;
    // normalise: sign 1, mag 0x10, E=9
    d = '0;
    d[7:0] = 8'h90;
    load(4'd9, d);
    check("norm_wait_valid", out_valid, 0);
    check("norm_busy_ready", in_ready, 0);
    step;
    check("norm_valid", out_valid, 1);
    check("norm_sign", out_sign, 1);
    check("norm_man", out_man, 7'h40);
    check("norm_exp", out_exp, 7);
    check("norm_idx", out_idx, 0);
    check("norm_last", out_last, 0);
    collect(0, 0, 0, beats, cycs);
    check("norm_beats", beats, 32);
    check("norm_done_ready", in_ready, 1);
    check("norm_done_valid", out_valid, 0);
    // underflow and negative zero
    out_ready = 0;
    d = rnd_blk();
    d[7:0] = 8'h01;
    d[15:8] = 8'h80;
    load(4'd3, d);
    step;
    check("uf_valid", out_valid, 1);
    check("uf_man", out_man, 7'h08);
    check("uf_exp", out_exp, 0);
    check("uf_sign", out_sign, 0);
    out_ready = 1;
    step;
    check("nz_idx", out_idx, 1);
    check("nz_elem", {out_sign, out_exp, out_man}, 0);
    collect(1, 0, 0, beats, cycs);
    check("uf_beats", beats, 31);
    // full-rate streaming
    d = {32{8'h7f}};
    out_ready = 1;
    load(4'd15, d);
    collect(0, 0, 0, beats, cycs);
    check("stream_beats", beats, 32);
    check("stream_cycles", cycs, 33);
    check("stream_ready_after", in_ready, 1);
    check("stream_valid_after", out_valid, 0);
    // backpressure with input gating
    load(4'd6, rnd_blk());
    collect(0, 1, 1, beats, cycs);
    check("bp_beats", beats, 32);
    check("bp_ready_after", in_ready, 1);
    // reset mid-block
    out_ready = 1;
    load(4'd10, rnd_blk());
    for (int i = 0; i < 60 && !(out_valid && out_idx == 5'd12); i++) step;
    check("rst_reach_idx12", out_idx, 12);
    rst = 1;
    step;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_outs", {out_sign, out_exp, out_man, out_idx, out_last}, 0);
    rst = 0;
    out_ready = 0;
    step;
    check("post_rst_quiet", out_valid, 0);
    load(4'd5, rnd_blk());
    step;
    check("restart_valid", out_valid, 1);
    check("restart_idx", out_idx, 0);
    collect(0, 0, 0, beats, cycs);
    check("restart_beats", beats, 32);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
